// File: rtl/risc16_control_fsm.sv
// Multi-cycle control sequencer for the RiSC-16 datapath: decodes the latched
// instruction and steps FETCH/DECODE/EXEC/MEM/WB with a memory watchdog.
module risc16_control_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic        eq,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  MUX_pc,
    output logic [1:0]  MUX_tgt,
    output logic        MUX_rf,
    output logic        WE_rf,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic        halted,
    output logic        err
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    // Opcode map: LW is 100 and SW is 101 in this datapath.
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] wait_reg;

    logic [2:0] opcode;
    logic       imm_zero;
    logic       reads_ra;
    logic [1:0] alu_op_dec;
    logic       alu_src_dec;
    logic       unused_bits;

    assign opcode      = instruction[15:13];
    assign imm_zero    = (instruction[6:0] == 7'd0);
    assign reads_ra    = (opcode == OP_SW) || (opcode == OP_BEQ);
    assign unused_bits = ^instruction[12:7];

    always_comb begin
        alu_op_dec  = 2'b00;
        alu_src_dec = 1'b0;
        case (opcode)
            OP_ADD:                 begin alu_op_dec = 2'b00; alu_src_dec = 1'b0; end
            OP_ADDI, OP_LW, OP_SW:  begin alu_op_dec = 2'b00; alu_src_dec = 1'b1; end
            OP_NAND:                alu_op_dec = 2'b01;
            OP_LUI:                 alu_op_dec = 2'b10;
            default:                alu_op_dec = 2'b00;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        MUX_pc       = 2'b00;
        MUX_tgt      = 2'b00;
        MUX_rf       = 1'b0;
        WE_rf        = 1'b0;
        alu_op       = 2'b00;
        alu_src      = 1'b0;
        state_next   = state_reg;
        if (rst) begin
            state_next = FETCH;
        end else begin
            case (state_reg)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    MUX_rf     = reads_ra;
                    state_next = EXEC;
                end
                EXEC: begin
                    MUX_rf  = reads_ra;
                    alu_op  = alu_op_dec;
                    alu_src = alu_src_dec;
                    case (opcode)
                        OP_BEQ: begin
                            pc_we      = 1'b1;
                            MUX_pc     = eq ? 2'b01 : 2'b00;
                            state_next = FETCH;
                        end
                        OP_JALR: begin
                            // Nonzero imm7 on JALR is the halt encoding.
                            if (imm_zero) begin
                                WE_rf      = 1'b1;
                                MUX_tgt    = 2'b10;
                                pc_we      = 1'b1;
                                MUX_pc     = 2'b10;
                                state_next = FETCH;
                            end else begin
                                state_next = HALT;
                            end
                        end
                        OP_LW, OP_SW: state_next = MEM;
                        default:      state_next = WB;
                    endcase
                end
                MEM: begin
                    MUX_rf       = reads_ra;
                    alu_op       = alu_op_dec;
                    alu_src      = alu_src_dec;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OP_SW);
                    if (mem_ready) begin
                        if (opcode == OP_SW) begin
                            pc_we      = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WB;
                        end
                    end
                end
                WB: begin
                    alu_op     = alu_op_dec;
                    alu_src    = alu_src_dec;
                    WE_rf      = 1'b1;
                    MUX_tgt    = (opcode == OP_LW) ? 2'b00 : 2'b01;
                    pc_we      = 1'b1;
                    state_next = FETCH;
                end
                HALT, ERR: state_next = state_reg;
                default:   state_next = FETCH;
            endcase
            // The wait that would bring the counter up to the limit trips the watchdog.
            if (TIMEOUT_CYCLES != 0 && mem_req && !mem_ready &&
                32'(wait_reg) == TIMEOUT_CYCLES - 1) begin
                state_next = ERR;
            end
        end
    end

    assign halted = !rst && (state_reg == HALT);
    assign err    = !rst && (state_reg == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (mem_req && !mem_ready && state_next == state_reg) begin
                wait_reg <= wait_reg + CW'(1);
            end else begin
                wait_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_risc16_control_fsm.sv
// Bench for risc16_control_fsm: each instruction is expanded into its expected
// per-cycle output trace from the phase rules and compared cycle by cycle.
module tb_risc16_control_fsm;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic        eq = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  MUX_pc, MUX_tgt;
    logic        MUX_rf, WE_rf;
    logic [1:0]  alu_op;
    logic        alu_src, halted, err;

    always #5 clk = ~clk;

    risc16_control_fsm #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .eq(eq),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
        .MUX_pc(MUX_pc), .MUX_tgt(MUX_tgt), .MUX_rf(MUX_rf), .WE_rf(WE_rf),
        .alu_op(alu_op), .alu_src(alu_src), .halted(halted), .err(err)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] mux_pc;
        logic [1:0] mux_tgt;
        logic       mux_rf;
        logic       we_rf;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       halted;
        logic       err;
    } outs_t;

    typedef struct packed {
        logic        rst;
        logic        mr;
        logic        eq;
        logic [15:0] ins;
        outs_t       v;
        outs_t       c;
    } step_t;

    step_t       plan[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] cur_ins = 16'h0000;

    localparam logic [15:0] I_ADD   = 16'b000_101_001_0000_011;
    localparam logic [15:0] I_LW    = 16'b100_110_101_0001110;
    localparam logic [15:0] I_SW    = 16'b101_010_011_0000100;
    localparam logic [15:0] I_BEQ   = 16'b110_001_011_0000101;
    localparam logic [15:0] I_JALR  = 16'b111_111_001_0000000;
    localparam logic [15:0] I_HALT  = 16'b111_111_001_0000001;
    localparam logic [15:0] I_NAND  = 16'b010_011_100_0000111;
    localparam logic [15:0] I_LUI   = 16'b011_001_1010101010;
    localparam logic [15:0] I_ADDI  = 16'b001_010_010_1111111;

    function automatic outs_t observed();
        outs_t o;
        o.mem_req = mem_req;  o.mem_we = mem_we;  o.mem_addr_sel = mem_addr_sel;
        o.ir_we = ir_we;      o.pc_we = pc_we;    o.mux_pc = MUX_pc;
        o.mux_tgt = MUX_tgt;  o.mux_rf = MUX_rf;  o.we_rf = WE_rf;
        o.alu_op = alu_op;    o.alu_src = alu_src;
        o.halted = halted;    o.err = err;
        return o;
    endfunction

    // Strobes and status flags are defined in every cycle.
    function automatic outs_t care_strobes();
        outs_t c = '0;
        c.mem_req = 1'b1; c.mem_we = 1'b1; c.ir_we = 1'b1; c.pc_we = 1'b1;
        c.we_rf = 1'b1;   c.halted = 1'b1; c.err = 1'b1;
        return c;
    endfunction

    function automatic void push(input logic r, input logic mr, input logic e,
                                 input logic [15:0] ins, input outs_t v, input outs_t c);
        step_t s;
        s.rst = r; s.mr = mr; s.eq = e; s.ins = ins; s.v = v; s.c = c;
        plan.push_back(s);
    endfunction

    function automatic void push_terminal(input logic is_err);
        outs_t v, c, call;
        for (int i = 0; i < 3; i++) begin
            v = '0; c = care_strobes();
            if (is_err) v.err = 1'b1; else v.halted = 1'b1;
            push(1'b0, 1'($urandom), 1'($urandom), cur_ins, v, c);
        end
        call = '1; call.halted = 1'b0; call.err = 1'b0;
        push(1'b1, 1'($urandom), 1'($urandom), cur_ins, '0, call);
    endfunction

    // Expected trace of one instruction: fw fetch waits, mw memory waits.
    function automatic void build_plan(input logic [15:0] ins, input int fw,
                                       input int mw, input logic eq_v);
        outs_t v, c;
        logic [2:0] op = ins[15:13];
        logic ra = (op == 3'b101) || (op == 3'b110);
        plan.delete();
        for (int i = 0; i < fw && i < int'(TO); i++) begin
            v = '0; c = care_strobes(); v.mem_req = 1'b1; c.mem_addr_sel = 1'b1;
            push(1'b0, 1'b0, 1'($urandom), 16'($urandom), v, c);
        end
        if (fw >= int'(TO)) begin push_terminal(1'b1); return; end
        v = '0; c = care_strobes(); v.mem_req = 1'b1; v.ir_we = 1'b1; c.mem_addr_sel = 1'b1;
        push(1'b0, 1'b1, 1'($urandom), cur_ins, v, c);
        cur_ins = ins;
        v = '0; c = care_strobes(); v.mux_rf = ra; c.mux_rf = 1'b1;
        push(1'b0, 1'($urandom), 1'($urandom), ins, v, c);
        v = '0; c = care_strobes(); v.mux_rf = ra; c.mux_rf = 1'b1;
        case (op)
            3'b000:                 begin v.alu_op = 2'b00; v.alu_src = 1'b0; c.alu_op = '1; c.alu_src = 1'b1; end
            3'b001, 3'b100, 3'b101: begin v.alu_op = 2'b00; v.alu_src = 1'b1; c.alu_op = '1; c.alu_src = 1'b1; end
            3'b010:                 begin v.alu_op = 2'b01; c.alu_op = '1; end
            3'b011:                 begin v.alu_op = 2'b10; c.alu_op = '1; end
            3'b110:                 begin v.pc_we = 1'b1; v.mux_pc = eq_v ? 2'b01 : 2'b00; c.mux_pc = '1; end
            default: begin
                if (ins[6:0] == 7'd0) begin
                    v.we_rf = 1'b1; v.mux_tgt = 2'b10; v.pc_we = 1'b1; v.mux_pc = 2'b10;
                    c.mux_tgt = '1; c.mux_pc = '1;
                end
            end
        endcase
        push(1'b0, 1'($urandom), eq_v, ins, v, c);
        if (op == 3'b111 && ins[6:0] != 7'd0) begin push_terminal(1'b0); return; end
        if (op == 3'b100 || op == 3'b101) begin
            for (int i = 0; i < mw && i < int'(TO); i++) begin
                v = '0; c = care_strobes(); c.mem_addr_sel = 1'b1;
                v.mem_req = 1'b1; v.mem_addr_sel = 1'b1; v.mem_we = (op == 3'b101);
                push(1'b0, 1'b0, 1'($urandom), ins, v, c);
            end
            if (mw >= int'(TO)) begin push_terminal(1'b1); return; end
            v = '0; c = care_strobes(); c.mem_addr_sel = 1'b1;
            v.mem_req = 1'b1; v.mem_addr_sel = 1'b1; v.mem_we = (op == 3'b101);
            if (op == 3'b101) begin v.pc_we = 1'b1; v.mux_pc = 2'b00; c.mux_pc = '1; end
            push(1'b0, 1'b1, 1'($urandom), ins, v, c);
        end
        if (op <= 3'b100) begin
            v = '0; c = care_strobes(); c.mux_tgt = '1; c.mux_pc = '1;
            v.we_rf = 1'b1; v.pc_we = 1'b1; v.mux_pc = 2'b00;
            v.mux_tgt = (op == 3'b100) ? 2'b00 : 2'b01;
            push(1'b0, 1'($urandom), 1'($urandom), ins, v, c);
        end
    endfunction

    task automatic apply_plan(input string name);
        outs_t obs;
        foreach (plan[i]) begin
            rst = plan[i].rst; mem_ready = plan[i].mr;
            eq = plan[i].eq;   instruction = plan[i].ins;
            @(negedge clk);
            obs = observed();
            vectors++;
            if ((obs & plan[i].c) !== (plan[i].v & plan[i].c)) begin
                miscompares++;
                $display("FAIL %s ins=%h cycle %0d: got %b, expected %b (care %b)",
                         name, plan[i].ins, i, obs, plan[i].v, plan[i].c);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        outs_t obs, exp_o;
        outs_t care;
        care = '1; care.halted = 1'b0; care.err = 1'b0;
        rst = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = observed(); vectors++;
            if ((obs & care) !== '0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got %b, expected all zero", i, obs);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        obs = observed(); vectors++;
        exp_o = '0; exp_o.mem_req = 1'b1; exp_o.ir_we = 1'b1;
        if (obs !== exp_o) begin
            miscompares++;
            $display("FAIL reset_first_fetch: got %b, expected %b", obs, exp_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        obs = observed(); vectors++;
        if ((obs & care) !== '0) begin
            miscompares++;
            $display("FAIL reset_in_decode: got %b, expected all zero", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        build_plan(I_ADD, 0, 0, 1'b0);  apply_plan("add");
        build_plan(I_LW, 0, 2, 1'b0);   apply_plan("lw_wait2");
        build_plan(I_BEQ, 0, 0, 1'b1);  apply_plan("beq_taken");
        build_plan(I_BEQ, 1, 0, 1'b0);  apply_plan("beq_not_taken");
        build_plan(I_JALR, 0, 0, 1'b0); apply_plan("jalr");
        build_plan(I_SW, 1, 1, 1'b0);   apply_plan("sw");
        build_plan(I_NAND, 0, 0, 1'b0); apply_plan("nand");
        build_plan(I_LUI, 2, 0, 1'b0);  apply_plan("lui");
        build_plan(I_ADDI, 0, 0, 1'b1); apply_plan("addi");
    endtask

    task automatic test_halt();
        build_plan(I_HALT, 0, 0, 1'b0); apply_plan("halt");
        build_plan(I_ADD, 0, 0, 1'b0);  apply_plan("after_halt");
    endtask

    task automatic test_watchdog();
        build_plan(I_ADD, 4, 0, 1'b0);  apply_plan("wd_fetch");
        build_plan(I_LW, 0, 4, 1'b0);   apply_plan("wd_mem");
        build_plan(I_SW, 3, 3, 1'b0);   apply_plan("wd_just_under");
        build_plan(I_LW, 3, 3, 1'b0);   apply_plan("wd_just_under_lw");
    endtask

    task automatic test_reset_mid_mem();
        outs_t obs, exp_o;
        build_plan(I_LW, 0, 2, 1'b0);
        while (plan.size() > 4) void'(plan.pop_back());
        apply_plan("mid_mem_prefix");
        rst = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        obs = observed(); vectors++;
        if (obs.mem_req !== 1'b0 || obs.mem_addr_sel !== 1'b0 || obs.we_rf !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_mem: got mem_req=%b mem_addr_sel=%b WE_rf=%b, expected 0 0 0",
                     obs.mem_req, obs.mem_addr_sel, obs.we_rf);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        obs = observed(); vectors++;
        exp_o = '0; exp_o.mem_req = 1'b1;
        if (obs !== exp_o) begin
            miscompares++;
            $display("FAIL fetch_after_rst_mid_mem: got %b, expected %b", obs, exp_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int fw, mw;
        for (int n = 0; n < 60; n++) begin
            ins = 16'($urandom);
            if (ins[15:13] == 3'b111 && $urandom_range(0, 2) != 0) ins[6:0] = 7'd0;
            fw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
            build_plan(ins, fw, mw, 1'($urandom));
            apply_plan("random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_halt();
        test_watchdog();
        test_reset_mid_mem();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
